// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream
//   CHANNELS x WIDTH-bit valid/ready inputs funnelled into one registered
//   valid/ready output slot. The channel is picked by `selector` (mode 0) or
//   by an internal arbiter (mode 1).
//
//   Build option: define MUX_NTO1_ROUND_ROBIN_EN for a round-robin arbiter in
//   mode 1. If it is left undefined, mode 1 uses fixed priority (the lowest
//   valid index wins) and no pointer register is built.
module mux_nto1_stream #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] input_data,
  input  logic [CHANNELS-1:0]       input_valid,
  output logic [CHANNELS-1:0]       input_ready,
  input  logic                      mode,
  input  logic [SEL_WIDTH-1:0]      selector,
  output logic [WIDTH-1:0]          output_data,
  output logic                      output_valid,
  input  logic                      output_ready,
  output logic [SEL_WIDTH-1:0]      output_chan
);

  logic                 load_en;    // output slot can accept a word this cycle
  logic [CHANNELS-1:0]  sel_grant;  // mode 0 grant
  logic [CHANNELS-1:0]  arb_grant;  // mode 1 grant
  logic [CHANNELS-1:0]  grant;      // one-hot or zero
  logic [SEL_WIDTH-1:0] grant_idx;
  logic [WIDTH-1:0]     grant_data;
  logic                 take;       // a transfer happens at the next edge

  // The slot is free when it is empty or when its word leaves this cycle.
  // Loading at the same edge as the drain gives full throughput.
  assign load_en = !output_valid || output_ready;

  // Explicit select: grant follows the selected channel's valid. A selector
  // value beyond the last channel never matches, so nothing is granted.
  always_comb begin
    // NOTE: defaulting every output of a combinational block before the
    // conditional logic keeps it purely combinational (no latch inferred).
    sel_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(selector) == i) sel_grant[i] = input_valid[i];
    end
  end

  assign grant = mode ? arb_grant : sel_grant;

  // Ready only for the granted channel, and never while reset is held, even
  // though the empty slot would otherwise look free.
  assign input_ready = reset_n ? (grant & {CHANNELS{load_en}}) : '0;
  assign take        = |input_ready;

  // Encode the one-hot grant into an index and steer the data for that channel.
  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        grant_idx  = SEL_WIDTH'(i);
        grant_data = input_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output slot: load on a transfer, clear valid on a drain with no reload.
  // Data and channel hold their values whenever nothing is loaded.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so that every
    // flop samples its inputs at the pre-edge values; this avoids races
    // that depend on evaluation order.
    if (!reset_n) begin
      output_valid <= 1'b0;
      output_data  <= '0;
      output_chan  <= '0;
    end else if (take) begin
      output_valid <= 1'b1;
      output_data  <= grant_data;
      output_chan  <= grant_idx;
    end else if (output_ready) begin
      output_valid <= 1'b0;
    end
  end

`ifdef MUX_NTO1_ROUND_ROBIN_EN

  logic [SEL_WIDTH-1:0] rr_ptr;     // first channel to consider next time
  int                   best_dist;  // smallest wrap distance among valid channels

  // Round-robin arbiter: pick the valid channel closest to the pointer when
  // counting upward and wrapping from CHANNELS-1 back to 0.
  always_comb begin
    arb_grant = '0;
    best_dist = CHANNELS;
    for (int i = 0; i < CHANNELS; i++) begin
      int dist;
      dist = i - int'(rr_ptr);
      if (dist < 0) dist = dist + CHANNELS;
      if (input_valid[i] && (dist < best_dist)) best_dist = dist;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      int dist;
      dist = i - int'(rr_ptr);
      if (dist < 0) dist = dist + CHANNELS;
      if (input_valid[i] && (dist == best_dist)) arb_grant[i] = 1'b1;
    end
  end

  // The pointer moves past the channel just served by the arbiter. Transfers
  // in explicit-select mode leave it untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (take && mode) begin
      if (int'(grant_idx) == CHANNELS - 1) rr_ptr <= '0;
      else                                 rr_ptr <= grant_idx + SEL_WIDTH'(1);
    end
  end

`else

  logic arb_found;

  // Fixed-priority arbiter: the lowest-index valid channel wins.
  always_comb begin
    arb_grant = '0;
    arb_found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (input_valid[i] && !arb_found) begin
        arb_grant[i] = 1'b1;
        arb_found    = 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream
//   Self-checking bench for mux_nto1_stream (CHANNELS = 4, WIDTH = 32).
//   SEL_WIDTH is 3, so selector values beyond the last channel can be driven.
//   Mode-1 expectations follow MUX_NTO1_ROUND_ROBIN_EN when that macro is
//   defined for the build.
module tb_mux_nto1_stream;

  localparam int WIDTH     = 32;
  localparam int CHANNELS  = 4;
  localparam int SEL_WIDTH = 3;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [CHANNELS*WIDTH-1:0] input_data;
  logic [CHANNELS-1:0]       input_valid;
  logic [CHANNELS-1:0]       input_ready;
  logic                      mode;
  logic [SEL_WIDTH-1:0]      selector;
  logic [WIDTH-1:0]          output_data;
  logic                      output_valid;
  logic                      output_ready;
  logic [SEL_WIDTH-1:0]      output_chan;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mux_nto1_stream #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .SEL_WIDTH(SEL_WIDTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .input_data  (input_data),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .mode        (mode),
    .selector    (selector),
    .output_data (output_data),
    .output_valid(output_valid),
    .output_ready(output_ready),
    .output_chan (output_chan)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic set_ch(input int c, input logic [WIDTH-1:0] d);
    input_data[c*WIDTH +: WIDTH] = d;
  endtask

  // ---------------- behavioural reference model ----------------
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_chan;
  int               m_ptr;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_ptr   = 0;
  endtask

  // Channel that should win this cycle, or -1 when no channel is granted.
  function automatic int pick(input logic md, input int sel, input logic [CHANNELS-1:0] v, input int ptr);
    if (!md) begin
      if (sel < CHANNELS) begin
        if (v[sel]) return sel;
      end
      return -1;
    end
`ifdef MUX_NTO1_ROUND_ROBIN_EN
    for (int k = 0; k < CHANNELS; k++) begin
      if (v[(ptr + k) % CHANNELS]) return (ptr + k) % CHANNELS;
    end
`else
    for (int k = 0; k < CHANNELS; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Compare the DUT against the model for the current inputs (on the falling
  // edge), then move the model across the next rising edge. The task returns
  // 1 ns after that edge, which is when the caller drives the next inputs.
  task automatic cycle_check(input string tag);
    int                  g;
    logic                take;
    logic [CHANNELS-1:0] one;
    logic [CHANNELS-1:0] exp_rdy;
    one = 1;
    @(negedge clock);
    check({tag, ".out_valid"}, 64'(output_valid), 64'(m_valid));
    check({tag, ".out_data"},  64'(output_data),  64'(m_data));
    check({tag, ".out_chan"},  64'(output_chan),  64'(m_chan));
    g       = pick(mode, int'(selector), input_valid, m_ptr);
    take    = (g >= 0) && (!m_valid || output_ready);
    exp_rdy = take ? (one << g) : '0;
    check({tag, ".in_ready"}, 64'(input_ready), 64'(exp_rdy));
    @(posedge clock);
    if (take) begin
      m_valid = 1'b1;
      m_data  = input_data[g*WIDTH +: WIDTH];
      m_chan  = g;
      if (mode) m_ptr = (g + 1) % CHANNELS;
    end else if (output_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // ---------------- grant table (checked from an empty output slot) ----------------
  typedef struct {
    string               name;
    logic                md;
    logic [SEL_WIDTH-1:0] sel;
    logic [CHANNELS-1:0] vld;
    logic                ordy;
    logic [CHANNELS-1:0] exp_rdy;
  } vec_t;

  function automatic vec_t mk(input string n, input logic md, input logic [SEL_WIDTH-1:0] s,
                              input logic [CHANNELS-1:0] v, input logic o, input logic [CHANNELS-1:0] e);
    vec_t r;
    r.name = n; r.md = md; r.sel = s; r.vld = v; r.ordy = o; r.exp_rdy = e;
    return r;
  endfunction

  vec_t vecs[11];
  int   exp_seq_a[$];
  int   exp_seq_b[$];

  initial begin
    // The pointer is 0 for every mode-1 row, so round robin and fixed
    // priority must agree: the lowest valid index wins.
    vecs[0]  = mk("tbl.m0_sel2",      1'b0, 3'd2, 4'b1111, 1'b1, 4'b0100);
    vecs[1]  = mk("tbl.m0_sel5",      1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000);
    vecs[2]  = mk("tbl.m0_sel4",      1'b0, 3'd4, 4'b1111, 1'b0, 4'b0000);
    vecs[3]  = mk("tbl.m0_sel3_inv",  1'b0, 3'd3, 4'b0111, 1'b1, 4'b0000);
    vecs[4]  = mk("tbl.m0_sel3",      1'b0, 3'd3, 4'b1000, 1'b0, 4'b1000);
    vecs[5]  = mk("tbl.m0_sel0",      1'b0, 3'd0, 4'b0001, 1'b1, 4'b0001);
    vecs[6]  = mk("tbl.m1_1010",      1'b1, 3'd0, 4'b1010, 1'b1, 4'b0010);
    vecs[7]  = mk("tbl.m1_1000",      1'b1, 3'd6, 4'b1000, 1'b1, 4'b1000);
    vecs[8]  = mk("tbl.m1_none",      1'b1, 3'd1, 4'b0000, 1'b1, 4'b0000);
    vecs[9]  = mk("tbl.m1_1111",      1'b1, 3'd3, 4'b1111, 1'b0, 4'b0001);
    vecs[10] = mk("tbl.m1_1100",      1'b1, 3'd0, 4'b1100, 1'b1, 4'b0100);

    // ---- reset state ----
    reset_n      = 1'b0;
    input_data   = '0;
    input_valid  = '0;
    mode         = 1'b0;
    selector     = '0;
    output_ready = 1'b0;
    model_reset();
    #1;
    check("rst.out_valid", 64'(output_valid), 64'd0);
    check("rst.out_data",  64'(output_data),  64'd0);
    check("rst.out_chan",  64'(output_chan),  64'd0);
    input_valid = 4'b1111;
    #1;
    check("rst.in_ready",  64'(input_ready),  64'd0);
    input_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // ---- grant table ----
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 32'h1000_0000 + c);
    foreach (vecs[i]) begin
      @(negedge clock);
      mode         = vecs[i].md;
      selector     = vecs[i].sel;
      input_valid  = vecs[i].vld;
      output_ready = vecs[i].ordy;
      #1;
      check(vecs[i].name, 64'(input_ready), 64'(vecs[i].exp_rdy));
      input_valid  = '0;   // withdrawn before the rising edge: no transfer
    end
    check("tbl.slot_empty", 64'(output_valid), 64'd0);
    @(posedge clock);
    #1;

    // ---- T2: explicit select, selector beyond range ----
    mode = 1'b0; selector = 3'd2; input_valid = 4'b1111; output_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 32'h2000_0000 + c);
    set_ch(2, 32'hDEADBEEF);
    cycle_check("t2.load");
    check("t2.data", 64'(output_data), 64'hDEADBEEF);
    check("t2.chan", 64'(output_chan), 64'd2);
    selector = 3'd5;
    #1;
    check("t2.sel5_ready", 64'(input_ready), 64'd0);
    cycle_check("t2.sel5");
    check("t2.sel5_drained", 64'(output_valid), 64'd0);

    // ---- T3: backpressure ----
    selector = 3'd2; input_valid = 4'b0100; output_ready = 1'b1;
    set_ch(2, 32'h3333_0001);
    cycle_check("t3.load");
    output_ready = 1'b0;
    set_ch(2, 32'h3333_0002);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3.stall_ready", 64'(input_ready), 64'd0);
      cycle_check("t3.stall");
      check("t3.stall_data", 64'(output_data), 64'h3333_0001);
    end
    output_ready = 1'b1;
    cycle_check("t3.release");
    check("t3.next_data", 64'(output_data), 64'h3333_0002);
    input_valid = '0;
    cycle_check("t3.drain");
    check("t3.drained_valid", 64'(output_valid), 64'd0);
    check("t3.hold_data", 64'(output_data), 64'h3333_0002);

    // ---- T4 / T5: arbitrated mode ----
    mode = 1'b1; output_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) set_ch(c, 32'hA000_0000 + c);
`ifdef MUX_NTO1_ROUND_ROBIN_EN
    input_valid = 4'b1111;
    exp_seq_a = '{0, 1, 2, 3, 0};
    exp_seq_b = '{2, 3, 0, 2};
`else
    input_valid = 4'b1010;
    exp_seq_a = '{1, 1, 1};
    exp_seq_b = '{3, 3};
`endif
    foreach (exp_seq_a[i]) begin
      cycle_check("t4.seq_a");
      check("t4.seq_a_chan", 64'(output_chan), 64'(exp_seq_a[i]));
    end
    input_valid[1] = 1'b0;
    foreach (exp_seq_b[i]) begin
      cycle_check("t4.seq_b");
      check("t4.seq_b_chan", 64'(output_chan), 64'(exp_seq_b[i]));
    end

    // ---- T6: 16-word stream on channel 0 ----
    mode = 1'b0; selector = 3'd0; input_valid = 4'b0001; output_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      set_ch(0, 32'h6000_0000 + w);
      cycle_check("t6.stream");
      check("t6.valid", 64'(output_valid), 64'd1);
      check("t6.data",  64'(output_data),  64'(32'h6000_0000 + w));
    end
    input_valid = '0;
    cycle_check("t6.drain");

    // ---- T1: reset with a word pending ----
    selector = 3'd1; input_valid = 4'b0010; output_ready = 1'b0;
    set_ch(1, 32'hCAFE_F00D);
    cycle_check("t1.load");
    check("t1.pending", 64'(output_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1.rst_valid", 64'(output_valid), 64'd0);
    check("t1.rst_data",  64'(output_data),  64'd0);
    check("t1.rst_chan",  64'(output_chan),  64'd0);
    check("t1.rst_ready", 64'(input_ready),  64'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    // Pointer must be back at 0: all channels valid must serve channel 0 first.
    mode = 1'b1; input_valid = 4'b1111; output_ready = 1'b1;
    cycle_check("t1.after");
    check("t1.ptr_zero_chan", 64'(output_chan), 64'd0);

    // ---- randomized run against the model ----
    for (int n = 0; n < 3000; n++) begin
      mode         = 1'($urandom_range(0, 1));
      selector     = 3'($urandom_range(0, 7));
      input_valid  = 4'($urandom);
      output_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CHANNELS; c++) set_ch(c, $urandom);
      cycle_check("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
